// File: rtl/lspc_pkg.sv
// Shared types and constants for the LSPC CPU-side VRAM access arbiter.
package lspc_pkg;
  localparam int SLOW_AW_DEF = 15;
  localparam int FAST_AW_DEF = 11;

  localparam logic ZONE_SLOW = 1'b0;
  localparam logic ZONE_FAST = 1'b1;

  // CPU register offsets (word index from 3C0000)
  localparam logic [2:0] REG_VRAMADDR = 3'b000;
  localparam logic [2:0] REG_VRAMRW   = 3'b001;
  localparam logic [2:0] REG_VRAMMOD  = 3'b010;

  typedef enum logic [2:0] {IDLE, WAIT_W, WR, WAIT_R, RD, CAP} arb_state_e;

  typedef struct packed {
    logic we_slow;
    logic we_fast;
    logic rd_slow;
    logic rd_fast;
  } vram_strb_t;
endpackage

// File: rtl/lspc_vram_ptr.sv
// CPU VRAM pointer: load, VRAMMOD auto-increment (zone bit preserved), zone decode.
module lspc_vram_ptr
  import lspc_pkg::*;
#(
  parameter int SLOW_AW = SLOW_AW_DEF,
  parameter int FAST_AW = FAST_AW_DEF
) (
  input  logic               CLK_24M,
  input  logic               nRESET,
  input  logic               load,
  input  logic [SLOW_AW:0]   din,
  input  logic               inc,
  input  logic [SLOW_AW-1:0] incr,
  output logic [SLOW_AW:0]   ptr,
  output logic               zone,
  output logic [SLOW_AW-1:0] vram_addr
);
  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET)   ptr <= '0;
    else if (load) ptr <= din;
    else if (inc)  ptr[SLOW_AW-1:0] <= ptr[SLOW_AW-1:0] + incr;
  end

  assign zone = ptr[SLOW_AW];
  // Fast zone keeps the full offset in the pointer but only drives its low bits.
  assign vram_addr = (zone == ZONE_FAST) ? SLOW_AW'(ptr[FAST_AW-1:0]) : ptr[SLOW_AW-1:0];
endmodule

// File: rtl/lspc_vram_arbiter.sv
// Slots CPU VRAM reads/writes into free video-fetch cycles.
// Optional stall statistics when LSPC_VRAM_ARB_STALL_EN is defined.
module lspc_vram_arbiter
  import lspc_pkg::*;
#(
  parameter int SLOW_AW = SLOW_AW_DEF,
  parameter int FAST_AW = FAST_AW_DEF,
  parameter int DW      = 16,
  parameter int STALL_W = 16
) (
  input  logic               CLK_24M,
  input  logic               nRESET,
  input  logic               WR_ADDR_STB,
  input  logic               WR_DATA_STB,
  input  logic [DW-1:0]      CPU_DIN,
  input  logic [DW-1:0]      VRAMMOD,
  input  logic               SLOT_SLOW,
  input  logic               SLOT_FAST,
  input  logic [DW-1:0]      VRAM_RDATA,
  output logic [SLOW_AW-1:0] VRAM_ADDR,
  output logic [DW-1:0]      VRAM_WDATA,
  output logic               VRAM_WE_SLOW,
  output logic               VRAM_WE_FAST,
  output logic               VRAM_RD_SLOW,
  output logic               VRAM_RD_FAST,
  output logic [DW-1:0]      READ_BUFFER,
`ifdef LSPC_VRAM_ARB_STALL_EN
  output logic [STALL_W-1:0] STALL_CNT,
  output logic [STALL_W-1:0] STALL_MAX,
`endif
  output logic [SLOW_AW:0]   CUR_ADDR,
  output logic               BUSY
);
  arb_state_e state, nxt;
  vram_strb_t strb_q, strb_d;
  logic [DW-1:0] wbuf;
  logic zone, slot, inc, cap;
  logic [DW-1:SLOW_AW] unused_mod;

  assign unused_mod = VRAMMOD[DW-1:SLOW_AW];

  lspc_vram_ptr #(.SLOW_AW(SLOW_AW), .FAST_AW(FAST_AW)) u_ptr (
    .CLK_24M   (CLK_24M),
    .nRESET    (nRESET),
    .load      (WR_ADDR_STB),
    .din       (CPU_DIN[SLOW_AW:0]),
    .inc       (inc),
    .incr      (VRAMMOD[SLOW_AW-1:0]),
    .ptr       (CUR_ADDR),
    .zone      (zone),
    .vram_addr (VRAM_ADDR)
  );

  assign slot = (zone == ZONE_FAST) ? SLOT_FAST : SLOT_SLOW;

  always_comb begin
    nxt    = state;
    strb_d = '0;
    inc    = 1'b0;
    cap    = 1'b0;
    if (WR_ADDR_STB) begin
      nxt = WAIT_R;
    end else if (WR_DATA_STB) begin
      // A write landing on an active WR lets that write finish (and advance).
      nxt = WAIT_W;
      inc = (state == WR);
    end else begin
      unique case (state)
        WAIT_W: if (slot) begin
          nxt            = WR;
          strb_d.we_slow = (zone == ZONE_SLOW);
          strb_d.we_fast = (zone == ZONE_FAST);
        end
        WR: begin
          nxt = WAIT_R;
          inc = 1'b1;
        end
        WAIT_R: if (slot) begin
          nxt            = RD;
          strb_d.rd_slow = (zone == ZONE_SLOW);
          strb_d.rd_fast = (zone == ZONE_FAST);
        end
        RD:  nxt = CAP;
        CAP: begin
          nxt = IDLE;
          cap = 1'b1;
        end
        default: nxt = state;
      endcase
    end
  end

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      state       <= IDLE;
      strb_q      <= '0;
      wbuf        <= '0;
      VRAM_WDATA  <= '0;
      READ_BUFFER <= '0;
    end else begin
      state  <= nxt;
      strb_q <= strb_d;
      if (WR_DATA_STB && !WR_ADDR_STB) wbuf <= CPU_DIN;
      // Separate output copy keeps write data stable if the CPU re-writes during WR.
      if (strb_d.we_slow || strb_d.we_fast) VRAM_WDATA <= wbuf;
      if (cap) READ_BUFFER <= VRAM_RDATA;
    end
  end

  assign VRAM_WE_SLOW = strb_q.we_slow;
  assign VRAM_WE_FAST = strb_q.we_fast;
  assign VRAM_RD_SLOW = strb_q.rd_slow;
  assign VRAM_RD_FAST = strb_q.rd_fast;
  assign BUSY         = (state != IDLE);

`ifdef LSPC_VRAM_ARB_STALL_EN
  logic               waiting;
  logic [STALL_W-1:0] cur_wait, cur_len;

  assign waiting = (state == WAIT_W) || (state == WAIT_R);
  assign cur_len = !waiting ? '0 : (&cur_wait ? cur_wait : cur_wait + 1'b1);

  always_ff @(posedge CLK_24M or negedge nRESET) begin
    if (!nRESET) begin
      STALL_CNT <= '0;
      STALL_MAX <= '0;
      cur_wait  <= '0;
    end else begin
      if (WR_ADDR_STB)                 STALL_CNT <= '0;
      else if (waiting && ~&STALL_CNT) STALL_CNT <= STALL_CNT + 1'b1;
      cur_wait <= cur_len;
      if (cur_len > STALL_MAX) STALL_MAX <= cur_len;
    end
  end
`endif
endmodule

// File: tb/tb_lspc_vram_arbiter.sv
// Directed self-checking bench for lspc_vram_arbiter (default build).
module tb_lspc_vram_arbiter;
  logic        CLK_24M = 1'b0;
  logic        nRESET = 1'b0;
  logic        WR_ADDR_STB = 1'b0, WR_DATA_STB = 1'b0;
  logic [15:0] CPU_DIN = '0, VRAMMOD = 16'd1, VRAM_RDATA = '0;
  logic        SLOT_SLOW = 1'b0, SLOT_FAST = 1'b0;
  logic [14:0] VRAM_ADDR;
  logic [15:0] VRAM_WDATA, READ_BUFFER, CUR_ADDR;
  logic        VRAM_WE_SLOW, VRAM_WE_FAST, VRAM_RD_SLOW, VRAM_RD_FAST, BUSY;

  int n_cmp = 0;
  int n_err = 0;

  lspc_vram_arbiter dut (
    .CLK_24M(CLK_24M), .nRESET(nRESET),
    .WR_ADDR_STB(WR_ADDR_STB), .WR_DATA_STB(WR_DATA_STB),
    .CPU_DIN(CPU_DIN), .VRAMMOD(VRAMMOD),
    .SLOT_SLOW(SLOT_SLOW), .SLOT_FAST(SLOT_FAST), .VRAM_RDATA(VRAM_RDATA),
    .VRAM_ADDR(VRAM_ADDR), .VRAM_WDATA(VRAM_WDATA),
    .VRAM_WE_SLOW(VRAM_WE_SLOW), .VRAM_WE_FAST(VRAM_WE_FAST),
    .VRAM_RD_SLOW(VRAM_RD_SLOW), .VRAM_RD_FAST(VRAM_RD_FAST),
    .READ_BUFFER(READ_BUFFER), .CUR_ADDR(CUR_ADDR), .BUSY(BUSY)
  );

  always #5 CLK_24M = ~CLK_24M;

  task automatic pulse_addr(input logic [15:0] v);
    @(negedge CLK_24M); WR_ADDR_STB = 1'b1; CPU_DIN = v;
    @(negedge CLK_24M); WR_ADDR_STB = 1'b0;
  endtask

  task automatic pulse_data(input logic [15:0] v);
    @(negedge CLK_24M); WR_DATA_STB = 1'b1; CPU_DIN = v;
    @(negedge CLK_24M); WR_DATA_STB = 1'b0;
  endtask

  // Returns at the negedge where the granted strobe is visible.
  task automatic pulse_slot(input logic s, input logic f);
    @(negedge CLK_24M); SLOT_SLOW = s; SLOT_FAST = f;
    @(negedge CLK_24M); SLOT_SLOW = 1'b0; SLOT_FAST = 1'b0;
  endtask

  task automatic test_reset;
    logic [4:0] strb;
    nRESET = 1'b0;
    repeat (2) @(negedge CLK_24M);
    strb = {VRAM_WE_SLOW, VRAM_WE_FAST, VRAM_RD_SLOW, VRAM_RD_FAST, BUSY};
    n_cmp++; if (strb !== 5'b0) begin n_err++; $display("FAIL reset_strobes: got %b want 00000", strb); end
    n_cmp++; if ({VRAM_ADDR, VRAM_WDATA, READ_BUFFER, CUR_ADDR} !== 63'd0) begin
      n_err++; $display("FAIL reset_data: addr %h wdata %h rbuf %h cur %h want all 0", VRAM_ADDR, VRAM_WDATA, READ_BUFFER, CUR_ADDR); end
    nRESET = 1'b1;
  endtask

  task automatic test_read;
    pulse_addr(16'h1234);
    n_cmp++; if (BUSY !== 1'b1 || CUR_ADDR !== 16'h1234) begin
      n_err++; $display("FAIL read_pending: busy %b cur %h want 1 1234", BUSY, CUR_ADDR); end
    repeat (2) @(negedge CLK_24M);
    n_cmp++; if (VRAM_RD_SLOW !== 1'b0) begin n_err++; $display("FAIL read_early: rd %b want 0", VRAM_RD_SLOW); end
    pulse_slot(1'b1, 1'b0);
    n_cmp++; if (VRAM_RD_SLOW !== 1'b1 || VRAM_RD_FAST !== 1'b0 || VRAM_ADDR !== 15'h1234) begin
      n_err++; $display("FAIL read_strobe: rd_s %b rd_f %b addr %h want 1 0 1234", VRAM_RD_SLOW, VRAM_RD_FAST, VRAM_ADDR); end
    VRAM_RDATA = 16'hBEEF;
    @(negedge CLK_24M);
    n_cmp++; if (VRAM_RD_SLOW !== 1'b0 || BUSY !== 1'b1) begin
      n_err++; $display("FAIL read_one_cycle: rd %b busy %b want 0 1", VRAM_RD_SLOW, BUSY); end
    @(negedge CLK_24M);
    n_cmp++; if (READ_BUFFER !== 16'hBEEF || BUSY !== 1'b0) begin
      n_err++; $display("FAIL read_capture: rbuf %h busy %b want beef 0", READ_BUFFER, BUSY); end
  endtask

  task automatic test_write_then_read;
    VRAMMOD = 16'd1;
    pulse_addr(16'h0100);
    pulse_data(16'h5A5A);
    pulse_slot(1'b1, 1'b0);
    n_cmp++; if (VRAM_WE_SLOW !== 1'b1 || VRAM_RD_SLOW !== 1'b0 || VRAM_ADDR !== 15'h0100 || VRAM_WDATA !== 16'h5A5A) begin
      n_err++; $display("FAIL write_strobe: we %b rd %b addr %h wd %h want 1 0 0100 5a5a", VRAM_WE_SLOW, VRAM_RD_SLOW, VRAM_ADDR, VRAM_WDATA); end
    @(negedge CLK_24M);
    n_cmp++; if (VRAM_WE_SLOW !== 1'b0 || CUR_ADDR !== 16'h0101) begin
      n_err++; $display("FAIL write_incr: we %b cur %h want 0 0101", VRAM_WE_SLOW, CUR_ADDR); end
    pulse_slot(1'b1, 1'b0);
    n_cmp++; if (VRAM_RD_SLOW !== 1'b1 || VRAM_ADDR !== 15'h0101) begin
      n_err++; $display("FAIL write_readback: rd %b addr %h want 1 0101", VRAM_RD_SLOW, VRAM_ADDR); end
    VRAM_RDATA = 16'h1111;
    repeat (2) @(negedge CLK_24M);
    n_cmp++; if (READ_BUFFER !== 16'h1111 || BUSY !== 1'b0) begin
      n_err++; $display("FAIL write_readbuf: rbuf %h busy %b want 1111 0", READ_BUFFER, BUSY); end
  endtask

  task automatic test_fast_zone;
    int seen = 0;
    pulse_addr(16'h8400);
    pulse_data(16'hA5A5);
    SLOT_SLOW = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK_24M);
      if (VRAM_WE_SLOW || VRAM_WE_FAST || VRAM_RD_SLOW || VRAM_RD_FAST) seen++;
    end
    SLOT_SLOW = 1'b0;
    n_cmp++; if (seen !== 0 || BUSY !== 1'b1) begin
      n_err++; $display("FAIL fast_ignore_slow: strobe cycles %0d busy %b want 0 1", seen, BUSY); end
    pulse_slot(1'b0, 1'b1);
    n_cmp++; if (VRAM_WE_FAST !== 1'b1 || VRAM_WE_SLOW !== 1'b0 || VRAM_ADDR !== 15'h0400 || VRAM_WDATA !== 16'hA5A5) begin
      n_err++; $display("FAIL fast_write: wf %b ws %b addr %h wd %h want 1 0 0400 a5a5", VRAM_WE_FAST, VRAM_WE_SLOW, VRAM_ADDR, VRAM_WDATA); end
    @(negedge CLK_24M);
    n_cmp++; if (CUR_ADDR !== 16'h8401) begin n_err++; $display("FAIL fast_incr: cur %h want 8401", CUR_ADDR); end
  endtask

  task automatic test_wrap;
    VRAMMOD = 16'd1;
    pulse_addr(16'h7FFF);
    pulse_data(16'h0001);
    pulse_slot(1'b1, 1'b0);
    @(negedge CLK_24M);
    n_cmp++; if (CUR_ADDR !== 16'h0000) begin n_err++; $display("FAIL wrap_slow: cur %h want 0000", CUR_ADDR); end
    pulse_addr(16'hFFFF);
    pulse_data(16'h0002);
    pulse_slot(1'b0, 1'b1);
    n_cmp++; if (VRAM_WE_FAST !== 1'b1 || VRAM_ADDR !== 15'h07FF) begin
      n_err++; $display("FAIL wrap_fast_addr: wf %b addr %h want 1 07ff", VRAM_WE_FAST, VRAM_ADDR); end
    @(negedge CLK_24M);
    n_cmp++; if (CUR_ADDR !== 16'h8000) begin n_err++; $display("FAIL wrap_fast: cur %h want 8000", CUR_ADDR); end
  endtask

  task automatic test_addr_override;
    pulse_addr(16'h0200);
    pulse_data(16'h3333);
    pulse_addr(16'h0010);
    pulse_slot(1'b1, 1'b0);
    n_cmp++; if (VRAM_RD_SLOW !== 1'b1 || VRAM_WE_SLOW !== 1'b0 || VRAM_ADDR !== 15'h0010) begin
      n_err++; $display("FAIL override_read: rd %b we %b addr %h want 1 0 0010", VRAM_RD_SLOW, VRAM_WE_SLOW, VRAM_ADDR); end
    repeat (2) @(negedge CLK_24M);
    @(negedge CLK_24M); WR_ADDR_STB = 1'b1; WR_DATA_STB = 1'b1; CPU_DIN = 16'h0020;
    @(negedge CLK_24M); WR_ADDR_STB = 1'b0; WR_DATA_STB = 1'b0;
    pulse_slot(1'b1, 1'b0);
    n_cmp++; if (VRAM_RD_SLOW !== 1'b1 || VRAM_WE_SLOW !== 1'b0 || VRAM_ADDR !== 15'h0020) begin
      n_err++; $display("FAIL same_cycle_strobes: rd %b we %b addr %h want 1 0 0020", VRAM_RD_SLOW, VRAM_WE_SLOW, VRAM_ADDR); end
    repeat (2) @(negedge CLK_24M);
  endtask

  task automatic test_back_to_back;
    pulse_addr(16'h0500);
    pulse_data(16'h1111);
    pulse_slot(1'b1, 1'b0);
    WR_DATA_STB = 1'b1; CPU_DIN = 16'h2222;
    @(negedge CLK_24M); WR_DATA_STB = 1'b0;
    n_cmp++; if (VRAM_WE_SLOW !== 1'b0 || CUR_ADDR !== 16'h0501 || BUSY !== 1'b1) begin
      n_err++; $display("FAIL b2b_requeue: we %b cur %h busy %b want 0 0501 1", VRAM_WE_SLOW, CUR_ADDR, BUSY); end
    pulse_slot(1'b1, 1'b0);
    n_cmp++; if (VRAM_WE_SLOW !== 1'b1 || VRAM_WDATA !== 16'h2222 || VRAM_ADDR !== 15'h0501) begin
      n_err++; $display("FAIL b2b_second_write: we %b wd %h addr %h want 1 2222 0501", VRAM_WE_SLOW, VRAM_WDATA, VRAM_ADDR); end
  endtask

  task automatic test_reset_mid_write;
    pulse_addr(16'h0300);
    pulse_data(16'h7777);
    pulse_slot(1'b1, 1'b0);
    #2 nRESET = 1'b0;
    #1;
    n_cmp++; if ({VRAM_WE_SLOW, VRAM_WE_FAST, VRAM_RD_SLOW, VRAM_RD_FAST, BUSY} !== 5'b0) begin
      n_err++; $display("FAIL midreset_strobes: we_s %b busy %b want 0 0", VRAM_WE_SLOW, BUSY); end
    n_cmp++; if ({VRAM_ADDR, VRAM_WDATA, READ_BUFFER, CUR_ADDR} !== 63'd0) begin
      n_err++; $display("FAIL midreset_data: addr %h wd %h rbuf %h cur %h want all 0", VRAM_ADDR, VRAM_WDATA, READ_BUFFER, CUR_ADDR); end
    @(negedge CLK_24M); nRESET = 1'b1;
    pulse_addr(16'h0042);
    pulse_slot(1'b1, 1'b0);
    n_cmp++; if (VRAM_RD_SLOW !== 1'b1 || VRAM_ADDR !== 15'h0042) begin
      n_err++; $display("FAIL postreset_read: rd %b addr %h want 1 0042", VRAM_RD_SLOW, VRAM_ADDR); end
    VRAM_RDATA = 16'hCAFE;
    repeat (2) @(negedge CLK_24M);
    n_cmp++; if (READ_BUFFER !== 16'hCAFE || BUSY !== 1'b0) begin
      n_err++; $display("FAIL postreset_rbuf: rbuf %h busy %b want cafe 0", READ_BUFFER, BUSY); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write_then_read();
    test_fast_zone();
    test_wrap();
    test_addr_override();
    test_back_to_back();
    test_reset_mid_write();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
